// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch stage, ROM and decoder.
package fetch_pkg;

    localparam int A_DEF = 8;
    localparam int W_DEF = 9;

    localparam logic [W_DEF-1:0] HALT_INST = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_INC,
        PC_ABS,
        PC_REL
    } pc_sel_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC mux: increment, absolute target, or PC-relative target.
// Zero latency; no backpressure (pure function of its inputs).
module pc_next_calc
    import fetch_pkg::*;
#(
    parameter int A = A_DEF
) (
    input  logic [A-1:0] pc,
    input  logic [A-1:0] inst_pc,
    input  logic [A-1:0] target,
    input  pc_sel_t      sel,
    output logic [A-1:0] next_pc
);

    // The offset is already A bits wide, so sign extension followed by a
    // modulo-2**A add reduces to a plain A-bit add.
    always_comb begin
        next_pc = pc;
        case (sel)
            PC_INC:  next_pc = pc + A'(1);
            PC_ABS:  next_pc = target;
            PC_REL:  next_pc = inst_pc + target;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/prog_ctr_fetch.sv
// Program counter and fetch stage: drives the ROM address, registers the returned word,
// resolves branches from decode with a one-bubble squash, and detects the halt word.
// One-cycle fetch latency; Stall freezes fetch state while CycleCount keeps counting.
module prog_ctr_fetch
    import fetch_pkg::*;
#(
    parameter int            A     = A_DEF,
    parameter int            W     = W_DEF,
    parameter logic [A-1:0]  START = '0,
    parameter int            CW    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchAbs,
    input  logic          BranchRel,
    input  logic [A-1:0]  Target,
    input  logic [W-1:0]  InstIn,
    output logic [A-1:0]  InstAddress,
    output logic [W-1:0]  InstReg,
    output logic [A-1:0]  InstPC,
    output logic          InstValid,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    fetch_state_t state, state_next;
    logic [A-1:0] pc, next_pc;
    pc_sel_t      pc_sel;
    logic         start_run, load_pc, fetch, squash, halt;

    pc_next_calc #(.A(A)) u_pc_next_calc (
        .pc      (pc),
        .inst_pc (InstPC),
        .target  (Target),
        .sel     (pc_sel),
        .next_pc (next_pc)
    );

    assign InstAddress = pc;

    always_comb begin
        state_next = state;
        pc_sel     = PC_INC;
        start_run  = 1'b0;
        load_pc    = 1'b0;
        fetch      = 1'b0;
        squash     = 1'b0;
        halt       = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    start_run  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (InstValid && (&InstReg)) begin
                        halt       = 1'b1;
                        state_next = HALTED;
                    end else if (InstValid && BranchAbs) begin
                        pc_sel  = PC_ABS;
                        load_pc = 1'b1;
                        squash  = 1'b1;
                    end else if (InstValid && BranchRel) begin
                        pc_sel  = PC_REL;
                        load_pc = 1'b1;
                        squash  = 1'b1;
                    end else begin
                        pc_sel  = PC_INC;
                        load_pc = 1'b1;
                        fetch   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= '0;
            InstReg    <= '0;
            InstPC     <= '0;
            InstValid  <= 1'b0;
            Done       <= 1'b0;
            CycleCount <= '0;
        end else begin
            state <= state_next;
            if (start_run) begin
                pc         <= START;
                InstValid  <= 1'b0;
                CycleCount <= '0;
                Done       <= 1'b0;
            end
            if (state == RUN && CycleCount != '1) begin
                CycleCount <= CycleCount + CW'(1);
            end
            if (load_pc) begin
                pc <= next_pc;
            end
            if (fetch) begin
                InstReg   <= InstIn;
                InstPC    <= pc;
                InstValid <= 1'b1;
            end
            if (squash) begin
                InstValid <= 1'b0;
            end
            if (halt) begin
                Done      <= 1'b1;
                InstValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_ctr_fetch.sv
// Directed bench for prog_ctr_fetch with a combinational ROM model.
module tb_prog_ctr_fetch;

    logic        Clk, Reset, Start, Stall, BranchAbs, BranchRel;
    logic [7:0]  Target;
    logic [8:0]  InstIn;
    logic [7:0]  InstAddress, InstPC;
    logic [8:0]  InstReg;
    logic        InstValid, Done;
    logic [15:0] CycleCount;

    logic [8:0]  rom [256];
    int          pass_cnt = 0;
    int          total_cnt = 0;

    assign InstIn = rom[InstAddress];

    prog_ctr_fetch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Stall       (Stall),
        .BranchAbs   (BranchAbs),
        .BranchRel   (BranchRel),
        .Target      (Target),
        .InstIn      (InstIn),
        .InstAddress (InstAddress),
        .InstReg     (InstReg),
        .InstPC      (InstPC),
        .InstValid   (InstValid),
        .Done        (Done),
        .CycleCount  (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
    endtask

    task automatic do_reset();
        Reset = 1'b1; step(1); Reset = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1; step(1); Start = 1'b0;
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset();
        total_cnt++; if (InstAddress !== 8'h00) $display("FAIL rst_pc got=%h exp=00", InstAddress); else pass_cnt++;
        total_cnt++; if (InstValid !== 1'b0 || Done !== 1'b0) $display("FAIL rst_flags got=%b%b exp=00", InstValid, Done); else pass_cnt++;
        total_cnt++; if (CycleCount !== 16'd0) $display("FAIL rst_cc got=%0d exp=0", CycleCount); else pass_cnt++;
        do_start();
        step(35);
        total_cnt++; if (InstAddress !== 8'h23) $display("FAIL t1_pc_run got=%h exp=23", InstAddress); else pass_cnt++;
        Reset = 1'b1; step(1); Reset = 1'b0;
        total_cnt++; if (InstAddress !== 8'h00) $display("FAIL t1_pc_mid got=%h exp=00", InstAddress); else pass_cnt++;
        total_cnt++; if (InstValid !== 1'b0 || Done !== 1'b0) $display("FAIL t1_flags got=%b%b exp=00", InstValid, Done); else pass_cnt++;
        total_cnt++; if (CycleCount !== 16'd0 || InstPC !== 8'h00) $display("FAIL t1_cc_ipc got=%0d/%h exp=0/00", CycleCount, InstPC); else pass_cnt++;
        step(2);
        total_cnt++; if (InstAddress !== 8'h00 || CycleCount !== 16'd0) $display("FAIL t1_idle_hold got=%h/%0d exp=00/0", InstAddress, CycleCount); else pass_cnt++;
    endtask

    task automatic test_halt();
        clear_rom();
        rom[0] = 9'h000; rom[1] = 9'h001; rom[2] = 9'h002; rom[3] = 9'h003; rom[4] = 9'h1FF;
        do_reset();
        do_start();
        total_cnt++; if (InstAddress !== 8'h00 || InstValid !== 1'b0) $display("FAIL t2_start got=%h/%b exp=00/0", InstAddress, InstValid); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step(1);
            total_cnt++; if (InstReg !== 9'(i) || InstValid !== 1'b1) $display("FAIL t2_fetch%0d got=%h/%b exp=%h/1", i, InstReg, InstValid, 9'(i)); else pass_cnt++;
        end
        step(1);
        total_cnt++; if (InstReg !== 9'h1FF || Done !== 1'b0 || InstPC !== 8'h04) $display("FAIL t2_haltword got=%h/%b/%h exp=1ff/0/04", InstReg, Done, InstPC); else pass_cnt++;
        step(1);
        total_cnt++; if (Done !== 1'b1 || InstValid !== 1'b0) $display("FAIL t2_done got=%b/%b exp=1/0", Done, InstValid); else pass_cnt++;
        total_cnt++; if (InstAddress !== 8'h05 || CycleCount !== 16'd6) $display("FAIL t2_pc_cc got=%h/%0d exp=05/6", InstAddress, CycleCount); else pass_cnt++;
        step(3);
        total_cnt++; if (InstAddress !== 8'h05 || CycleCount !== 16'd6 || Done !== 1'b1 || InstReg !== 9'h1FF) $display("FAIL t2_hold got=%h/%0d/%b/%h exp=05/6/1/1ff", InstAddress, CycleCount, Done, InstReg); else pass_cnt++;
    endtask

    task automatic test_restart();
        // Continues from the HALTED state left by test_halt.
        do_start();
        total_cnt++; if (InstAddress !== 8'h00 || Done !== 1'b0 || CycleCount !== 16'd0) $display("FAIL t6_restart got=%h/%b/%0d exp=00/0/0", InstAddress, Done, CycleCount); else pass_cnt++;
        step(1);
        Start = 1'b1; step(1); Start = 1'b0;
        total_cnt++; if (InstAddress !== 8'h02 || CycleCount !== 16'd2 || InstPC !== 8'h01) $display("FAIL t6_start_in_run got=%h/%0d/%h exp=02/2/01", InstAddress, CycleCount, InstPC); else pass_cnt++;
    endtask

    task automatic test_branch_rel();
        clear_rom();
        do_reset();
        do_start();
        step(17);
        total_cnt++; if (InstPC !== 8'h10 || InstAddress !== 8'h11 || InstValid !== 1'b1) $display("FAIL t3_setup got=%h/%h/%b exp=10/11/1", InstPC, InstAddress, InstValid); else pass_cnt++;
        BranchRel = 1'b1; Target = 8'hFD; step(1); BranchRel = 1'b0; Target = 8'h00;
        total_cnt++; if (InstAddress !== 8'h0D || InstValid !== 1'b0) $display("FAIL t3_rel got=%h/%b exp=0d/0", InstAddress, InstValid); else pass_cnt++;
        step(1);
        total_cnt++; if (InstPC !== 8'h0D || InstValid !== 1'b1 || InstAddress !== 8'h0E) $display("FAIL t3_after got=%h/%b/%h exp=0d/1/0e", InstPC, InstValid, InstAddress); else pass_cnt++;
    endtask

    task automatic test_branch_abs();
        clear_rom();
        do_reset();
        do_start();
        step(1);
        BranchAbs = 1'b1; BranchRel = 1'b1; Target = 8'h40; step(1);
        total_cnt++; if (InstAddress !== 8'h40 || InstValid !== 1'b0) $display("FAIL t4_abs_wins got=%h/%b exp=40/0", InstAddress, InstValid); else pass_cnt++;
        BranchRel = 1'b0; Target = 8'h80; step(1);
        BranchAbs = 1'b0; Target = 8'h00;
        total_cnt++; if (InstAddress !== 8'h41 || InstPC !== 8'h40 || InstValid !== 1'b1) $display("FAIL t4_ignored got=%h/%h/%b exp=41/40/1", InstAddress, InstPC, InstValid); else pass_cnt++;
    endtask

    task automatic test_wrap_stall();
        clear_rom();
        rom[8'hFF] = 9'h055; rom[0] = 9'h011;
        do_reset();
        do_start();
        step(1);
        BranchAbs = 1'b1; Target = 8'hFF; step(1); BranchAbs = 1'b0; Target = 8'h00;
        step(1);
        total_cnt++; if (InstAddress !== 8'h00 || InstPC !== 8'hFF || InstReg !== 9'h055) $display("FAIL t5_wrap got=%h/%h/%h exp=00/ff/055", InstAddress, InstPC, InstReg); else pass_cnt++;
        step(1);
        total_cnt++; if (CycleCount !== 16'd4 || InstReg !== 9'h011) $display("FAIL t5_pre_stall got=%0d/%h exp=4/011", CycleCount, InstReg); else pass_cnt++;
        Stall = 1'b1; BranchAbs = 1'b1; Target = 8'h30; step(3);
        total_cnt++; if (InstAddress !== 8'h01 || InstReg !== 9'h011 || InstPC !== 8'h00 || InstValid !== 1'b1) $display("FAIL t5_stall_hold got=%h/%h/%h/%b exp=01/011/00/1", InstAddress, InstReg, InstPC, InstValid); else pass_cnt++;
        total_cnt++; if (CycleCount !== 16'd7) $display("FAIL t5_stall_cc got=%0d exp=7", CycleCount); else pass_cnt++;
        Stall = 1'b0; BranchAbs = 1'b0; Target = 8'h00; step(1);
        total_cnt++; if (InstAddress !== 8'h02 || InstPC !== 8'h01 || CycleCount !== 16'd8) $display("FAIL t5_resume got=%h/%h/%0d exp=02/01/8", InstAddress, InstPC, CycleCount); else pass_cnt++;
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0;
        BranchAbs = 1'b0; BranchRel = 1'b0; Target = 8'h00;
        test_reset();
        test_halt();
        test_restart();
        test_branch_rel();
        test_branch_abs();
        test_wrap_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
